// File: rtl/result_writeback.sv
// Result writeback: buffers 6x6 PE result tiles from two ports and writes them
// row by row into accumulator memory, either overwriting or saturating-accumulating.
module result_writeback #(
  parameter int FIFO_DEPTH = 2,
  parameter int ACC_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          acc_clear_i,
  input  logic signed [5:0][5:0][11:0]  res0_tile_i,
  input  logic        [7:0]             res0_addr_i,
  input  logic                          res0_valid_i,
  input  logic signed [5:0][5:0][11:0]  res1_tile_i,
  input  logic        [7:0]             res1_addr_i,
  input  logic                          res1_valid_i,
  output logic        [10:0]            mem_addr_o,
  output logic                          mem_ren_o,
  input  logic        [6*ACC_W-1:0]     mem_rdata_i,
  output logic                          mem_wen_o,
  output logic        [6*ACC_W-1:0]     mem_wdata_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic        [15:0]            tile_count_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [5:0][5:0][11:0] tile;
    logic [7:0]            addr;
    logic                  clr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  entry_t                fifo_mem [2][FIFO_DEPTH];
  entry_t [1:0]          in_entry;
  entry_t [1:0]          head;
  entry_t                cur;
  logic   [1:0]          valid, push, full, empty, pop_p;
  logic   [1:0][PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic   [1:0][CW-1:0]  cnt_q, cnt_d;
  logic                  overflow_q, overflow_d;

  state_e                state_q, state_d;
  logic   [2:0]          row_q, row_d;
  logic                  sel_q, sel_d, prio_q, prio_d, pick, pop;
  logic   [10:0]         addr_q, addr_d;
  logic                  ren_q, ren_d, wen_q, wen_d;
  logic   [15:0]         count_q, count_d;

  assign valid       = {res1_valid_i, res0_valid_i};
  assign in_entry[0] = {res0_tile_i, res0_addr_i, acc_clear_i};
  assign in_entry[1] = {res1_tile_i, res1_addr_i, acc_clear_i};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      empty[p] = (cnt_q[p] == '0);
      head[p]  = fifo_mem[p][rd_ptr_q[p]];
    end
    cur = head[sel_q];
  end

  // Fullness uses the pre-pop count, so a same-cycle pop never makes room for a push.
  always_comb begin
    overflow_d = overflow_q;
    for (int p = 0; p < 2; p++) begin
      full[p]     = (cnt_q[p] == CW'(FIFO_DEPTH));
      push[p]     = valid[p] && !full[p];
      pop_p[p]    = pop && (sel_q == 1'(p));
      if (valid[p] && full[p]) overflow_d = 1'b1;
      wr_ptr_d[p] = push[p]  ? ptr_inc(wr_ptr_q[p]) : wr_ptr_q[p];
      rd_ptr_d[p] = pop_p[p] ? ptr_inc(rd_ptr_q[p]) : rd_ptr_q[p];
      cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(pop_p[p]);
    end
  end

  // NOTE: payload storage has no reset; the counts and pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) fifo_mem[p][wr_ptr_q[p]] <= in_entry[p];
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d = state_q;
    row_d   = row_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    count_d = count_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    pop     = 1'b0;
    pick    = empty[prio_q] ? ~prio_q : prio_q;
    case (state_q)
      IDLE: begin
        if (!(&empty)) begin
          sel_d  = pick;
          row_d  = 3'd0;
          addr_d = {head[pick].addr, 3'd0};
          if (head[pick].clr) begin
            state_d = WRITE;
            wen_d   = 1'b1;
          end else begin
            state_d = READ;
            ren_d   = 1'b1;
          end
        end
      end
      READ: begin
        state_d = WRITE;
        wen_d   = 1'b1;
      end
      WRITE: begin
        if (row_q == 3'd5) begin
          pop     = 1'b1;
          count_d = count_q + 16'd1;
          prio_d  = ~sel_q;
          state_d = IDLE;
        end else begin
          row_d  = row_q + 3'd1;
          addr_d = {cur.addr, row_q + 3'd1};
          if (cur.clr) begin
            state_d = WRITE;
            wen_d   = 1'b1;
          end else begin
            state_d = READ;
            ren_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write data is combinational: read data only arrives during the WRITE cycle itself.
  logic [11:0]      elem;
  logic [ACC_W-1:0] ext, rd_elem;
  logic [ACC_W:0]   sum;

  always_comb begin
    mem_wdata_o = '0;
    elem        = '0;
    ext         = '0;
    rd_elem     = '0;
    sum         = '0;
    if (state_q == WRITE) begin
      for (int c = 0; c < 6; c++) begin
        elem    = cur.tile[row_q][c];
        ext     = {{(ACC_W-12){elem[11]}}, elem};
        rd_elem = mem_rdata_i[c*ACC_W +: ACC_W];
        sum     = {rd_elem[ACC_W-1], rd_elem} + {ext[ACC_W-1], ext};
        if (cur.clr)
          mem_wdata_o[c*ACC_W +: ACC_W] = ext;
        else if (sum[ACC_W] != sum[ACC_W-1])
          mem_wdata_o[c*ACC_W +: ACC_W] = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                     : {1'b0, {(ACC_W-1){1'b1}}};
        else
          mem_wdata_o[c*ACC_W +: ACC_W] = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      sel_q      <= 1'b0;
      prio_q     <= 1'b0;
      addr_q     <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      sel_q      <= sel_d;
      prio_q     <= prio_d;
      addr_q     <= addr_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_ren_o    = ren_q;
  assign mem_wen_o    = wen_q;
  assign overflow_o   = overflow_q;
  assign tile_count_o = count_q;
  assign busy_o       = (state_q != IDLE) || !(&empty);

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: a behavioural accumulator memory plus
// scenario tasks that check write traffic, saturation, arbitration and reset.
module tb_result_writeback;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 acc_clear_i = 1'b0;
  logic [5:0][5:0][11:0] res0_tile_i = '0, res1_tile_i = '0;
  logic [7:0]           res0_addr_i = '0, res1_addr_i = '0;
  logic                 res0_valid_i = 1'b0, res1_valid_i = 1'b0;
  logic [10:0]          mem_addr_o;
  logic                 mem_ren_o, mem_wen_o, busy_o, overflow_o;
  logic [95:0]          mem_rdata_i = '0;
  logic [95:0]          mem_wdata_o;
  logic [15:0]          tile_count_o;

  int total = 0;
  int bad   = 0;

  result_writeback #(.FIFO_DEPTH(2), .ACC_W(16)) dut (
    .clk(clk), .reset(reset), .acc_clear_i(acc_clear_i),
    .res0_tile_i(res0_tile_i), .res0_addr_i(res0_addr_i), .res0_valid_i(res0_valid_i),
    .res1_tile_i(res1_tile_i), .res1_addr_i(res1_addr_i), .res1_valid_i(res1_valid_i),
    .mem_addr_o(mem_addr_o), .mem_ren_o(mem_ren_o), .mem_rdata_i(mem_rdata_i),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .tile_count_o(tile_count_o)
  );

  always #5 clk = ~clk;

  // Memory model with a one-cycle read latency, write log and backdoor preload port.
  logic [95:0] mem_model [0:2047];
  logic [10:0] log_addr  [0:255];
  logic [95:0] log_data  [0:255];
  int          log_n = 0, ren_n = 0, both_n = 0;
  logic        pre_en = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [95:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem_model[pre_addr] <= pre_data;
    if (mem_ren_o) begin
      mem_rdata_i <= mem_model[mem_addr_o];
      ren_n       <= ren_n + 1;
    end
    if (mem_wen_o) begin
      mem_model[mem_addr_o] <= mem_wdata_o;
      if (log_n < 256) begin
        log_addr[log_n] <= mem_addr_o;
        log_data[log_n] <= mem_wdata_o;
      end
      log_n <= log_n + 1;
    end
    if (mem_ren_o && mem_wen_o) both_n <= both_n + 1;
  end

  function automatic logic [431:0] uni(input int v);
    logic [5:0][5:0][11:0] t;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) t[r][c] = 12'(v);
    return t;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    for (int r = 0; r < 6; r++) begin
      pre_en   = 1'b1;
      pre_addr = {a, 3'(r)};
      pre_data = {6{v}};
      @(negedge clk);
    end
    pre_en = 1'b0;
  endtask

  task automatic strobe(input logic [1:0] ports, input logic clr,
                        input logic [7:0] a0, input logic [431:0] t0,
                        input logic [7:0] a1, input logic [431:0] t1);
    acc_clear_i  = clr;
    res0_addr_i  = a0;
    res0_tile_i  = t0;
    res1_addr_i  = a1;
    res1_tile_i  = t1;
    res0_valid_i = ports[0];
    res1_valid_i = ports[1];
    @(negedge clk);
    res0_valid_i = 1'b0;
    res1_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy_o=%b required 0 within 200 cycles", name, busy_o);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    total++;
    if ({mem_ren_o, mem_wen_o, busy_o, overflow_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: ren/wen/busy/ovf=%b required 0000",
               {mem_ren_o, mem_wen_o, busy_o, overflow_o});
    end
    total++;
    if (mem_addr_o !== 11'd0 || mem_wdata_o !== 96'd0 || tile_count_o !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: addr=%h wdata=%h count=%0d required 0/0/0",
               mem_addr_o, mem_wdata_o, tile_count_o);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int st = log_n;
    int rs = ren_n;
    strobe(2'b01, 1'b1, 8'h05, uni(3), 8'h00, uni(0));
    wait_idle("clear");
    total++;
    if (log_n - st !== 6 || ren_n - rs !== 0) begin
      bad++;
      $display("FAIL clear_traffic: writes=%0d reads=%0d required 6/0", log_n - st, ren_n - rs);
    end
    for (int r = 0; r < 6; r++) begin
      total++;
      if (log_addr[st+r] !== 11'h028 + 11'(r) || log_data[st+r] !== {6{16'd3}}) begin
        bad++;
        $display("FAIL clear_row%0d: addr=%h data=%h required %h/%h", r, log_addr[st+r],
                 log_data[st+r], 11'h028 + 11'(r), {6{16'd3}});
      end
    end
    total++;
    if (tile_count_o !== 16'd1) begin
      bad++;
      $display("FAIL clear_count: tile_count_o=%0d required 1", tile_count_o);
    end
  endtask

  task automatic test_accumulate();
    int st, rs;
    preload(8'h05, 16'd100);
    st = log_n;
    rs = ren_n;
    strobe(2'b01, 1'b0, 8'h05, uni(-7), 8'h00, uni(0));
    wait_idle("acc");
    total++;
    if (log_n - st !== 6 || ren_n - rs !== 6) begin
      bad++;
      $display("FAIL acc_traffic: writes=%0d reads=%0d required 6/6", log_n - st, ren_n - rs);
    end
    for (int r = 0; r < 6; r++) begin
      total++;
      if (log_addr[st+r] !== 11'h028 + 11'(r) || log_data[st+r] !== {6{16'd93}}) begin
        bad++;
        $display("FAIL acc_row%0d: addr=%h data=%h required %h/%h", r, log_addr[st+r],
                 log_data[st+r], 11'h028 + 11'(r), {6{16'd93}});
      end
    end
    total++;
    if (tile_count_o !== 16'd2) begin
      bad++;
      $display("FAIL acc_count: tile_count_o=%0d required 2", tile_count_o);
    end
  endtask

  task automatic test_saturation();
    int st;
    preload(8'h10, 16'd32760);
    preload(8'h11, 16'h8000);
    st = log_n;
    strobe(2'b01, 1'b0, 8'h10, uni(2047), 8'h00, uni(0));
    wait_idle("sat_pos");
    strobe(2'b01, 1'b0, 8'h11, uni(-1), 8'h00, uni(0));
    wait_idle("sat_neg");
    total++;
    if (log_n - st !== 12) begin
      bad++;
      $display("FAIL sat_traffic: writes=%0d required 12", log_n - st);
    end
    for (int r = 0; r < 6; r++) begin
      total++;
      if (log_data[st+r] !== {6{16'h7fff}} || log_data[st+6+r] !== {6{16'h8000}}) begin
        bad++;
        $display("FAIL sat_row%0d: pos=%h neg=%h required %h/%h", r, log_data[st+r],
                 log_data[st+6+r], {6{16'h7fff}}, {6{16'h8000}});
      end
    end
    total++;
    if (tile_count_o !== 16'd4) begin
      bad++;
      $display("FAIL sat_count: tile_count_o=%0d required 4", tile_count_o);
    end
  endtask

  task automatic test_pattern();
    logic [5:0][5:0][11:0] t;
    logic [95:0]           exp_row;
    int                    st;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) t[r][c] = 12'(r*16 + c - 40);
    st = log_n;
    strobe(2'b10, 1'b1, 8'h00, uni(0), 8'h20, t);
    wait_idle("pattern");
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) exp_row[c*16 +: 16] = 16'(r*16 + c - 40);
      total++;
      if (log_addr[st+r] !== 11'h100 + 11'(r) || log_data[st+r] !== exp_row) begin
        bad++;
        $display("FAIL pattern_row%0d: addr=%h data=%h required %h/%h", r, log_addr[st+r],
                 log_data[st+r], 11'h100 + 11'(r), exp_row);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st = log_n;
    strobe(2'b11, 1'b1, 8'h30, uni(1), 8'h31, uni(2));
    wait_idle("b2b");
    total++;
    if (log_n - st !== 12) begin
      bad++;
      $display("FAIL b2b_traffic: writes=%0d required 12", log_n - st);
    end
    for (int r = 0; r < 6; r++) begin
      total++;
      if (log_addr[st+r] !== 11'h180 + 11'(r) || log_data[st+r] !== {6{16'd1}} ||
          log_addr[st+6+r] !== 11'h188 + 11'(r) || log_data[st+6+r] !== {6{16'd2}}) begin
        bad++;
        $display("FAIL b2b_row%0d: p0 %h/%h p1 %h/%h required %h/%h %h/%h", r,
                 log_addr[st+r], log_data[st+r], log_addr[st+6+r], log_data[st+6+r],
                 11'h180 + 11'(r), {6{16'd1}}, 11'h188 + 11'(r), {6{16'd2}});
      end
    end
    total++;
    if (tile_count_o !== 16'd7) begin
      bad++;
      $display("FAIL b2b_count: tile_count_o=%0d required 7", tile_count_o);
    end
  endtask

  task automatic test_overflow();
    int st = log_n;
    total++;
    if (overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL ovf_before: overflow_o=%b required 0", overflow_o);
    end
    strobe(2'b01, 1'b1, 8'h40, uni(4), 8'h00, uni(0));
    strobe(2'b01, 1'b1, 8'h41, uni(5), 8'h00, uni(0));
    strobe(2'b01, 1'b1, 8'h42, uni(6), 8'h00, uni(0));
    total++;
    if (overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: overflow_o=%b required 1", overflow_o);
    end
    wait_idle("ovf");
    repeat (5) @(negedge clk);
    total++;
    if (overflow_o !== 1'b1 || log_n - st !== 12 || tile_count_o !== 16'd9) begin
      bad++;
      $display("FAIL ovf_after: overflow_o=%b writes=%0d count=%0d required 1/12/9",
               overflow_o, log_n - st, tile_count_o);
    end
    for (int r = 0; r < 6; r++) begin
      total++;
      if (log_addr[st+r] !== 11'h200 + 11'(r) || log_data[st+r] !== {6{16'd4}} ||
          log_addr[st+6+r] !== 11'h208 + 11'(r) || log_data[st+6+r] !== {6{16'd5}}) begin
        bad++;
        $display("FAIL ovf_row%0d: %h/%h then %h/%h required %h/%h %h/%h", r,
                 log_addr[st+r], log_data[st+r], log_addr[st+6+r], log_data[st+6+r],
                 11'h200 + 11'(r), {6{16'd4}}, 11'h208 + 11'(r), {6{16'd5}});
      end
    end
  endtask

  task automatic test_reset_mid();
    int  st, rs;
    logic hit = 1'b0;
    strobe(2'b01, 1'b0, 8'h05, uni(1), 8'h00, uni(0));
    for (int i = 0; i < 40; i++) begin
      if (mem_ren_o && mem_addr_o == 11'h02B) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (hit !== 1'b1) begin
      bad++;
      $display("FAIL mid_row3: row 3 read seen=%b required 1", hit);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mem_ren_o, mem_wen_o, busy_o, overflow_o} !== 4'b0000 || tile_count_o !== 16'd0 ||
        mem_addr_o !== 11'd0 || mem_wdata_o !== 96'd0) begin
      bad++;
      $display("FAIL mid_reset: ren/wen/busy/ovf=%b count=%0d addr=%h wdata=%h required 0000/0/0/0",
               {mem_ren_o, mem_wen_o, busy_o, overflow_o}, tile_count_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk);
    reset = 1'b1;
    st = log_n;
    rs = ren_n;
    repeat (20) @(negedge clk);
    total++;
    if (log_n - st !== 0 || ren_n - rs !== 0 || busy_o !== 1'b0 || tile_count_o !== 16'd0) begin
      bad++;
      $display("FAIL mid_quiet: writes=%0d reads=%0d busy=%b count=%0d required 0/0/0/0",
               log_n - st, ren_n - rs, busy_o, tile_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_accumulate();
    test_saturation();
    test_pattern();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    total++;
    if (both_n !== 0) begin
      bad++;
      $display("FAIL strobe_overlap: cycles with ren and wen both high=%0d required 0", both_n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: tile entries buffered per input port.
REQ-002 Parameter ACC_W, default 16: width of each accumulated output element.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 acc_clear_i  input  1  1 = overwrite (first input-depth pass), 0 = accumulate into stored value; captured per tile at acceptance.
REQ-006 res0_tile_i  input  signed [11:0] [5:0][5:0]  result tile from PE port 0.
REQ-007 res0_addr_i  input  8  tile address for port 0.
REQ-008 res0_valid_i  input  1  one-cycle strobe; tile and address valid.
REQ-009 res1_tile_i, res1_addr_i, res1_valid_i  input  same widths  port 1 equivalents.
REQ-010 mem_addr_o  output  11  {tile_addr[7:0], row[2:0]}, row 0..5.
REQ-011 mem_ren_o  output  1  read strobe.
REQ-012 mem_rdata_i  input  6*ACC_W  row data, valid exactly one cycle after mem_ren_o.
REQ-013 mem_wen_o  output  1  write strobe.
REQ-014 mem_wdata_o  output  6*ACC_W  row data, element c in bits [c*ACC_W +: ACC_W].
REQ-015 busy_o  output  1  FSM not IDLE or any FIFO non-empty.
REQ-016 overflow_o  output  1  sticky; a strobe arrived at a full FIFO.
REQ-017 tile_count_o  output  16  tiles fully written since reset, wraps at 65535 -> 0.

Function
REQ-018 Each port SHALL own a FIFO of FIFO_DEPTH entries {tile, addr, acc_clear}; a strobe pushes in the cycle it is high.
REQ-019 No backpressure exists; a strobe on a full FIFO SHALL be dropped and set overflow_o; a pop in the same cycle does not free space for it.
REQ-020 Arbiter SHALL be round-robin between non-empty FIFOs; port 0 has priority after reset; after serving port N, port 1-N has priority.
REQ-021 FSM states: IDLE, READ, WRITE; IDLE -> READ when a FIFO is non-empty and selected entry has acc_clear=0; IDLE -> WRITE when acc_clear=1.
REQ-022 READ: assert mem_ren_o with row address, -> WRITE next cycle.
REQ-023 WRITE: assert mem_wen_o with same address; data = sign-extended tile row (clear) or saturating per-element sum of mem_rdata_i and sign-extended tile row (accumulate).
REQ-024 Saturation SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-025 After WRITE of row r<5: row r+1 -> READ (accumulate) or WRITE (clear); after row 5: pop FIFO, increment tile_count_o, -> IDLE.
REQ-026 Per tile latency: 6 cycles (clear) or 12 cycles (accumulate) plus 1 IDLE cycle between tiles.
REQ-027 mem_ren_o and mem_wen_o SHALL never be high in the same cycle; neither is high in IDLE.
REQ-028 The entry being processed SHALL remain unchanged until popped; concurrent pushes to the same FIFO fill the next slot.

Reset
REQ-029 On reset low, immediately: FSM IDLE, FIFOs empty, mem_ren_o=0, mem_wen_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, overflow_o=0, tile_count_o=0, arbiter priority port 0.
REQ-030 Reset asserted mid-tile SHALL abandon the tile; no further memory strobes until a new strobe arrives after reset release.

Verification
REQ-031 Clear write: acc_clear_i=1, res0 strobe, addr 0x05, all elements 3 -> 6 writes to addresses 0x028..0x02D, each element 3, tile_count_o=1 after 6 cycles.
REQ-032 Accumulate: addr 0x05 memory holds 100 per element, acc_clear_i=0, tile of -7 -> 6 read/write pairs, written value 93, 12 cycles.
REQ-033 Saturation: stored 32760, tile element 2047, accumulate -> written 32767; stored -32768 plus -1 -> -32768.
REQ-034 Simultaneous strobes on both ports in one cycle -> port 0 tile fully written first, then port 1; tile_count_o=2.
REQ-035 Three port-0 strobes on consecutive cycles while busy (depth 2) -> third dropped, overflow_o=1 and stays 1; exactly 2 tiles written.
REQ-036 Reset low during row 3 of an accumulate tile -> strobes drop asynchronously, tile_count_o=0, busy_o=0.
